// File: rtl/wb_arbiter_2way.sv
// Two-master to one-target Wishbone arbiter. Ownership is round-robin and held
// for the whole cycle; a watchdog terminates transfers the target never acks.
module wb_arbiter_2way #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,

    input  logic                  wbs_a_cyc_i,
    input  logic                  wbs_a_stb_i,
    input  logic                  wbs_a_we_i,
    input  logic [3:0]            wbs_a_sel_i,
    input  logic [ADDR_WIDTH-1:0] wbs_a_adr_i,
    input  logic [31:0]           wbs_a_dat_i,
    output logic                  wbs_a_ack_o,
    output logic [31:0]           wbs_a_dat_o,

    input  logic                  wbs_b_cyc_i,
    input  logic                  wbs_b_stb_i,
    input  logic                  wbs_b_we_i,
    input  logic [3:0]            wbs_b_sel_i,
    input  logic [ADDR_WIDTH-1:0] wbs_b_adr_i,
    input  logic [31:0]           wbs_b_dat_i,
    output logic                  wbs_b_ack_o,
    output logic [31:0]           wbs_b_dat_o,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [31:0]           wbm_dat_i,

    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    // State encoding doubles as the one-hot {B,A} grant vector.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          WDOG_EN       = (TIMEOUT_CYCLES != 0);

    state_t      state_reg;
    logic        last_grant_reg;   // 0 = A owned last, 1 = B owned last
    logic [15:0] wdog_count_reg;

    logic                  req_a;
    logic                  req_b;
    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [3:0]            own_sel;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [31:0]           own_wdat;
    logic                  xfer_active;
    logic                  trip;
    logic                  own_ack;
    logic [31:0]           own_rdat;

    assign req_a = wbs_a_cyc_i & wbs_a_stb_i;
    assign req_b = wbs_b_cyc_i & wbs_b_stb_i;

    // Select the owning master's request signals; zero when nobody owns the bus.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_sel  = '0;
        own_adr  = '0;
        own_wdat = '0;
        case (state_reg)
            GRANT_A: begin
                own_cyc  = wbs_a_cyc_i;
                own_stb  = wbs_a_stb_i;
                own_we   = wbs_a_we_i;
                own_sel  = wbs_a_sel_i;
                own_adr  = wbs_a_adr_i;
                own_wdat = wbs_a_dat_i;
            end
            GRANT_B: begin
                own_cyc  = wbs_b_cyc_i;
                own_stb  = wbs_b_stb_i;
                own_we   = wbs_b_we_i;
                own_sel  = wbs_b_sel_i;
                own_adr  = wbs_b_adr_i;
                own_wdat = wbs_b_dat_i;
            end
            default: ;
        endcase
    end

    assign xfer_active = own_cyc & own_stb;

    // A real ack at the deadline takes precedence over the watchdog.
    assign trip = WDOG_EN && xfer_active && !wbm_ack_i
                  && (wdog_count_reg == TIMEOUT_LIMIT);

    // Acks are only honoured while the owner strobes, so a late ack is dropped.
    assign own_ack  = xfer_active & (wbm_ack_i | trip);
    assign own_rdat = trip ? TIMEOUT_DATA : wbm_dat_i;

    assign wbm_cyc_o = own_cyc;
    assign wbm_stb_o = xfer_active & ~trip;
    assign wbm_we_o  = own_cyc & own_we;
    assign wbm_sel_o = own_cyc ? own_sel  : '0;
    assign wbm_adr_o = own_cyc ? own_adr  : '0;
    assign wbm_dat_o = own_cyc ? own_wdat : '0;

    assign wbs_a_ack_o = (state_reg == GRANT_A) & own_ack;
    assign wbs_b_ack_o = (state_reg == GRANT_B) & own_ack;
    assign wbs_a_dat_o = (state_reg == GRANT_A) ? own_rdat : '0;
    assign wbs_b_dat_o = (state_reg == GRANT_B) ? own_rdat : '0;

    assign grant_o   = state_reg;
    assign timeout_o = trip;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            wdog_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_a && (!req_b || last_grant_reg)) begin
                        state_reg <= GRANT_A;
                    end else if (req_b) begin
                        state_reg <= GRANT_B;
                    end
                end
                GRANT_A: begin
                    if (!wbs_a_cyc_i) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b0;
                    end
                end
                GRANT_B: begin
                    if (!wbs_b_cyc_i) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (!WDOG_EN || !xfer_active || wbm_ack_i || trip) begin
                wdog_count_reg <= '0;
            end else begin
                wdog_count_reg <= wdog_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2way.sv
// Directed cycle-by-cycle vector bench for wb_arbiter_2way with a 4-cycle watchdog.
module tb_wb_arbiter_2way;

    localparam logic [31:0] A_ADR = 32'h3000_0010;
    localparam logic [31:0] A_DAT = 32'hA5A5_0001;
    localparam logic [3:0]  A_SEL = 4'hF;
    localparam logic [31:0] B_ADR = 32'h4000_0020;
    localparam logic [31:0] B_DAT = 32'hB0B0_0002;
    localparam logic [3:0]  B_SEL = 4'h3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_cyc = 0, a_stb = 0, b_cyc = 0, b_stb = 0, m_ack = 0;
    logic [31:0] m_rdat = '0;
    logic        a_ack, b_ack, m_cyc, m_stb, m_we, tmo;
    logic [31:0] a_rdat, b_rdat, m_adr, m_wdat;
    logic [3:0]  m_sel;
    logic [1:0]  grant;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter_2way #(
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .wbs_a_cyc_i(a_cyc),
        .wbs_a_stb_i(a_stb),
        .wbs_a_we_i(1'b0),
        .wbs_a_sel_i(A_SEL),
        .wbs_a_adr_i(A_ADR),
        .wbs_a_dat_i(A_DAT),
        .wbs_a_ack_o(a_ack),
        .wbs_a_dat_o(a_rdat),
        .wbs_b_cyc_i(b_cyc),
        .wbs_b_stb_i(b_stb),
        .wbs_b_we_i(1'b1),
        .wbs_b_sel_i(B_SEL),
        .wbs_b_adr_i(B_ADR),
        .wbs_b_dat_i(B_DAT),
        .wbs_b_ack_o(b_ack),
        .wbs_b_dat_o(b_rdat),
        .wbm_cyc_o(m_cyc),
        .wbm_stb_o(m_stb),
        .wbm_we_o(m_we),
        .wbm_sel_o(m_sel),
        .wbm_adr_o(m_adr),
        .wbm_dat_o(m_wdat),
        .wbm_ack_i(m_ack),
        .wbm_dat_i(m_rdat),
        .grant_o(grant),
        .timeout_o(tmo)
    );

    typedef struct {
        logic        rst;      // pulse async reset before applying this cycle
        logic [4:0]  in;       // {a_cyc, a_stb, b_cyc, b_stb, wbm_ack}
        logic [31:0] mdat;
        logic [1:0]  g;
        logic [1:0]  m;        // {wbm_cyc, wbm_stb}
        logic [2:0]  acks;     // {a_ack, b_ack, timeout}
        logic [31:0] a_dat;
        logic [31:0] b_dat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic rst, input logic [4:0] in, input logic [31:0] mdat,
                               input logic [1:0] g, input logic [1:0] m, input logic [2:0] acks,
                               input logic [31:0] a_dat, input logic [31:0] b_dat);
        vec_t r;
        r.rst = rst; r.in = in; r.mdat = mdat; r.g = g; r.m = m;
        r.acks = acks; r.a_dat = a_dat; r.b_dat = b_dat;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_mcyc"}, 32'(m_cyc), 0);
        chk({tag, "_mstb"}, 32'(m_stb), 0);
        chk({tag, "_mwe"}, 32'(m_we), 0);
        chk({tag, "_msel"}, 32'(m_sel), 0);
        chk({tag, "_madr"}, m_adr, 0);
        chk({tag, "_mwdat"}, m_wdat, 0);
        chk({tag, "_aack"}, 32'(a_ack), 0);
        chk({tag, "_adat"}, a_rdat, 0);
        chk({tag, "_back"}, 32'(b_ack), 0);
        chk({tag, "_bdat"}, b_rdat, 0);
        chk({tag, "_tmo"}, 32'(tmo), 0);
    endtask

    initial begin
        logic [31:0] e_adr, e_wdat;
        logic [3:0]  e_sel;
        logic        e_we;
        int          nfail_before;

        // Single master A read, 2-cycle target latency
        vq.push_back(v(1, 5'b11000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11000, 0,             2'b01, 2'b11, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11000, 0,             2'b01, 2'b11, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11001, 32'h1234_5678, 2'b01, 2'b11, 3'b100, 32'h1234_5678, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b01, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        // Tie from reset -> A, then B after one idle cycle, next tie -> A
        vq.push_back(v(1, 5'b11110, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11111, 32'h1111_1111, 2'b01, 2'b11, 3'b100, 32'h1111_1111, 0));
        vq.push_back(v(0, 5'b00110, 0,             2'b01, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11110, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11111, 32'h2222_2222, 2'b10, 2'b11, 3'b010, 0, 32'h2222_2222));
        vq.push_back(v(0, 5'b11000, 0,             2'b10, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11110, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11110, 0,             2'b01, 2'b11, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b01, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        // Locked burst: B keeps cyc through 4 acked writes while A waits
        vq.push_back(v(0, 5'b00110, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11111, 32'h0000_0001, 2'b10, 2'b11, 3'b010, 0, 32'h0000_0001));
        vq.push_back(v(0, 5'b11100, 0,             2'b10, 2'b10, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11111, 32'h0000_0002, 2'b10, 2'b11, 3'b010, 0, 32'h0000_0002));
        vq.push_back(v(0, 5'b11111, 32'h0000_0003, 2'b10, 2'b11, 3'b010, 0, 32'h0000_0003));
        vq.push_back(v(0, 5'b11111, 32'h0000_0004, 2'b10, 2'b11, 3'b010, 0, 32'h0000_0004));
        vq.push_back(v(0, 5'b11000, 0,             2'b10, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11001, 32'h0000_00AA, 2'b01, 2'b11, 3'b100, 32'h0000_00AA, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b01, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        // Watchdog trip on the 5th stb cycle, late ack ignored, then ack at the deadline
        vq.push_back(v(0, 5'b11000, 0,             2'b00, 2'b00, 3'b000, 0, 0));
        for (int k = 0; k < 4; k++)
            vq.push_back(v(0, 5'b11000, 0,         2'b01, 2'b11, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11000, 0,             2'b01, 2'b10, 3'b101, 32'hDEAD_BEEF, 0));
        vq.push_back(v(0, 5'b10001, 32'h5555_5555, 2'b01, 2'b10, 3'b000, 32'h5555_5555, 0));
        for (int k = 0; k < 4; k++)
            vq.push_back(v(0, 5'b11000, 0,         2'b01, 2'b11, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b11001, 32'h600D_D00D, 2'b01, 2'b11, 3'b100, 32'h600D_D00D, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b01, 2'b00, 3'b000, 0, 0));
        vq.push_back(v(0, 5'b00000, 0,             2'b00, 2'b00, 3'b000, 0, 0));

        // Reset state while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            if (vq[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            {a_cyc, a_stb, b_cyc, b_stb, m_ack} = vq[i].in;
            m_rdat = vq[i].mdat;
            @(negedge clk);
            nfail_before = fails;
            e_we = 1'b0; e_sel = '0; e_adr = '0; e_wdat = '0;
            if (vq[i].m[1] && vq[i].g == 2'b01) begin
                e_sel = A_SEL; e_adr = A_ADR; e_wdat = A_DAT;
            end else if (vq[i].m[1] && vq[i].g == 2'b10) begin
                e_we = 1'b1; e_sel = B_SEL; e_adr = B_ADR; e_wdat = B_DAT;
            end
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vq[i].g));
            chk($sformatf("v%0d_mcyc", i), 32'(m_cyc), 32'(vq[i].m[1]));
            chk($sformatf("v%0d_mstb", i), 32'(m_stb), 32'(vq[i].m[0]));
            chk($sformatf("v%0d_mwe", i), 32'(m_we), 32'(e_we));
            chk($sformatf("v%0d_msel", i), 32'(m_sel), 32'(e_sel));
            chk($sformatf("v%0d_madr", i), m_adr, e_adr);
            chk($sformatf("v%0d_mwdat", i), m_wdat, e_wdat);
            chk($sformatf("v%0d_aack", i), 32'(a_ack), 32'(vq[i].acks[2]));
            chk($sformatf("v%0d_back", i), 32'(b_ack), 32'(vq[i].acks[1]));
            chk($sformatf("v%0d_tmo", i), 32'(tmo), 32'(vq[i].acks[0]));
            chk($sformatf("v%0d_adat", i), a_rdat, vq[i].a_dat);
            chk($sformatf("v%0d_bdat", i), b_rdat, vq[i].b_dat);
            $display("[TB] vec %0d in=%b g=%b m=%b acks=%b adat=%h bdat=%h %s", i, vq[i].in,
                     grant, {m_cyc, m_stb}, {a_ack, b_ack, tmo}, a_rdat, b_rdat,
                     (fails == nfail_before) ? "ok" : "bad");
            @(posedge clk);
            #1;
        end

        // Async reset asserted between edges while A owns the bus with an ack pending
        {a_cyc, a_stb, b_cyc, b_stb, m_ack} = 5'b11000;
        m_rdat = '0;
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        m_rdat = 32'h7777_7777;
        #2;
        chk("mid_rst_pre_grant", 32'(grant), 32'(2'b01));
        chk("mid_rst_pre_ack", 32'(a_ack), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        $display("[TB] async reset mid-transfer grant=%b aack=%b mcyc=%b", grant, a_ack, m_cyc);
        @(posedge clk);
        #2;
        {a_cyc, a_stb, b_cyc, b_stb, m_ack} = 5'b00110;
        m_rdat = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_grant", 32'(grant), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_b_grant", 32'(grant), 32'(2'b10));
        chk("post_rst_b_madr", m_adr, B_ADR);
        chk("post_rst_b_mstb", 32'(m_stb), 1);
        chk("post_rst_aack", 32'(a_ack), 0);
        $display("[TB] post-reset B request grant=%b madr=%h", grant, m_adr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
